xyz_rectify_phase_pair_gen: RTL and testbench
=============================================

XYZ_RECTIFY_PHASE_PAIR_GEN -- requirements
Module: xyz_rectify_phase_pair_gen

Interface
REQ-001 SHALL have parameters: FBIT, default 8, fraction bits of the position and step; PHASE_DW, default 15, phase width; PASS_DW, default 8, pass-data width; LEN_W, default 11, line-length and step integer-part width.
REQ-002 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins one line.
- step  in  LEN_W+FBIT  unsigned fixed-point input-sample advance per output sample; must be greater than 0.
- in_len  in  LEN_W  input samples per line; must be at least 2.
- out_len  in  LEN_W  output pairs per line; must be at least 1.
- busy  out  1  high while a line is in progress.
- done  out  1  one-cycle pulse at end of line.
- src_phase  in  PHASE_DW  input phase sample.
- src_valid / src_ready  in / out  1 each  input handshake.
- phase1, phase2  out  PHASE_DW each  left and right neighbour samples.
- phase_frac  out  FBIT  interpolation fraction.
- phase_pass_data  out  PASS_DW  output index, out_cnt[PASS_DW-1:0].
- phase_valid / phase_ready  out / in  1 each  output handshake to the interpolator.

Function
REQ-003 SHALL implement states IDLE, FILL, RUN, DRAIN.
REQ-004 IDLE, on start:
- SHALL latch step, in_len and out_len;
- SHALL clear pos (LEN_W+FBIT bits), out_cnt, in_cnt and win_idx;
- SHALL go to FILL.
REQ-005 start SHALL be ignored in any state other than IDLE.
REQ-006 FILL SHALL assert src_ready and accept two samples into w0 and w1, then go to RUN.
REQ-007 In RUN, with pos_int = pos[LEN_W+FBIT-1:FBIT] and pos_frac = pos[FBIT-1:0]:
- pos_int == win_idx: SHALL present {w0, w1, pos_frac};
- pos_int > win_idx and in_cnt < in_len: SHALL assert src_ready and, on the input handshake, shift w0<=w1, w1<=src_phase, win_idx++, in_cnt++; no output is presented in that cycle;
- pos_int > win_idx and in_cnt == in_len (edge clamp): SHALL present {w1, w1, 0}.
REQ-008 On each output handshake SHALL perform pos += step and out_cnt++. When out_cnt reaches out_len SHALL go to DRAIN.
REQ-009 DRAIN SHALL accept and discard input samples until in_cnt == in_len, then pulse done for 1 cycle and go to IDLE. If in_cnt already equals in_len, done SHALL pulse in the cycle after the last output handshake.
REQ-010 Outputs SHALL be registered:
- phase_valid asserts the cycle after the pair is determined;
- phase1, phase2, phase_frac and phase_pass_data SHALL hold stable while phase_valid && !phase_ready;
- phase_valid SHALL not drop without a handshake.
REQ-011 Sustained throughput SHALL be 1 pair/cycle when no window shift is needed and phase_ready=1.
REQ-012 src_ready SHALL be 0 in IDLE and whenever no sample is needed. No input sample SHALL be lost or duplicated.
REQ-013 Phase values SHALL pass unmodified; wrap handling belongs to the downstream interpolator.
REQ-014 pos SHALL not overflow for legal configurations (out_len*step < 2^LEN_W); overflow behaviour is unspecified.
REQ-015 busy SHALL be high in FILL, RUN and DRAIN.

Reset
REQ-016 On rst SHALL go to IDLE and set busy, done, src_ready and phase_valid to 0, and phase1, phase2, phase_frac, phase_pass_data, pos and all counters to 0, effective the next edge, including mid-line. A start after reset SHALL operate normally.

Structure
REQ-017 FBIT and PHASE_DW defaults and the state enum SHALL live in the shared package xyz_rectify_pkg.
REQ-018 The output register plus hold logic SHALL be sub-module xyz_rectify_out_reg.

Verification
REQ-019 in_len=4, samples 100,200,300,400, step=256, out_len=4 -> pairs (100,200,0), (200,300,0), (300,400,0), (400,400,0); done 1 cycle after the last handshake.
REQ-020 in_len=2, samples 10,20, step=128, out_len=3 -> pairs (10,20,0), (10,20,128), (20,20,0).
REQ-021 in_len=5, samples 1..5, step=512, out_len=2 -> pairs (1,2,0), (3,4,0); sample 5 consumed in DRAIN; then done.
REQ-022 Random phase_ready (10% high) with 1024 random samples -> output sequence matches the golden model and outputs stay stable during stalls.
REQ-023 Samples 32700,50 -> (32700,50,f) emitted unmodified.
REQ-024 rst asserted mid-RUN -> next cycle phase_valid=0, src_ready=0, busy=0; the following line is correct.

Source files
------------

// File: rtl/xyz_rectify_pkg.sv
// Shared definitions for the phase-pair generator.
//   FBIT_DEF     : default fraction bits of position/step
//   PHASE_DW_DEF : default phase sample width
//   state_e      : line sequencing states
package xyz_rectify_pkg;

  localparam int FBIT_DEF     = 8;
  localparam int PHASE_DW_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/xyz_rectify_phase_pair_gen_if.sv
// Stream bundle for the phase-pair generator.
//   src_*   : input phase samples (valid/ready)
//   phase_* : neighbour pair + fraction + index to the interpolator (valid/ready)
// master = generator side, slave = source/sink side.
interface xyz_rectify_phase_pair_gen_if
  import xyz_rectify_pkg::*;
#(
  parameter int FBIT     = FBIT_DEF,
  parameter int PHASE_DW = PHASE_DW_DEF,
  parameter int PASS_DW  = 8
);

  logic [PHASE_DW-1:0] src_phase;
  logic                src_valid;
  logic                src_ready;

  logic [PHASE_DW-1:0] phase1;
  logic [PHASE_DW-1:0] phase2;
  logic [FBIT-1:0]     phase_frac;
  logic [PASS_DW-1:0]  phase_pass_data;
  logic                phase_valid;
  logic                phase_ready;

  modport master (
    input  src_phase, src_valid, phase_ready,
    output src_ready, phase1, phase2, phase_frac, phase_pass_data, phase_valid
  );

  modport slave (
    output src_phase, src_valid, phase_ready,
    input  src_ready, phase1, phase2, phase_frac, phase_pass_data, phase_valid
  );

endinterface

// File: rtl/xyz_rectify_out_reg.sv
// Single-entry output register with hold-under-backpressure.
//   clk, rst        : clock, synchronous active-high reset
//   ld_i, *_i       : load request and payload
//   rdy_i           : downstream ready
//   can_ld_o        : a load this cycle will be taken
//   vld_o, *_o      : registered payload towards the interpolator
// Payload only changes on a taken load, so it holds while vld_o && !rdy_i.
module xyz_rectify_out_reg #(
  parameter int PHASE_DW = 15,
  parameter int FBIT     = 8,
  parameter int PASS_DW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_i,
  input  logic [PHASE_DW-1:0] p1_i,
  input  logic [PHASE_DW-1:0] p2_i,
  input  logic [FBIT-1:0]     frac_i,
  input  logic [PASS_DW-1:0]  pass_i,
  input  logic                rdy_i,
  output logic                can_ld_o,
  output logic                vld_o,
  output logic [PHASE_DW-1:0] p1_o,
  output logic [PHASE_DW-1:0] p2_o,
  output logic [FBIT-1:0]     frac_o,
  output logic [PASS_DW-1:0]  pass_o
);

  logic                vld_q;
  logic [PHASE_DW-1:0] p1_q, p2_q;
  logic [FBIT-1:0]     frac_q;
  logic [PASS_DW-1:0]  pass_q;

  // empty, or current entry leaves this cycle: back-to-back loads allowed
  assign can_ld_o = !vld_q || rdy_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      p1_q   <= '0;
      p2_q   <= '0;
      frac_q <= '0;
      pass_q <= '0;
    end else if (ld_i && can_ld_o) begin
      vld_q  <= 1'b1;
      p1_q   <= p1_i;
      p2_q   <= p2_i;
      frac_q <= frac_i;
      pass_q <= pass_i;
    end else if (rdy_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign p1_o   = p1_q;
  assign p2_o   = p2_q;
  assign frac_o = frac_q;
  assign pass_o = pass_q;

endmodule

// File: rtl/xyz_rectify_phase_pair_gen.sv
// Resampling pair generator: walks a fixed-point position across one line
// of input phase samples and emits the bracketing sample pair plus the
// interpolation fraction for each output sample.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begins a line (taken only in IDLE)
//   step            : unsigned fixed-point advance per output (LEN_W.FBIT)
//   in_len, out_len : input samples / output pairs per line
//   busy, done      : line in progress / end-of-line pulse
//   bus (master)    : src_* input stream, phase_* output stream
module xyz_rectify_phase_pair_gen
  import xyz_rectify_pkg::*;
#(
  parameter int FBIT     = FBIT_DEF,
  parameter int PHASE_DW = PHASE_DW_DEF,
  parameter int PASS_DW  = 8,
  parameter int LEN_W    = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W+FBIT-1:0] step,
  input  logic [LEN_W-1:0]      in_len,
  input  logic [LEN_W-1:0]      out_len,
  output logic                  busy,
  output logic                  done,
  xyz_rectify_phase_pair_gen_if.master bus
);

  localparam int POS_W = LEN_W + FBIT;

  state_e              state_q, state_d;
  logic [POS_W-1:0]    step_q, step_d;
  logic [LEN_W-1:0]    in_len_q, in_len_d;
  logic [LEN_W-1:0]    out_len_q, out_len_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [LEN_W-1:0]    out_cnt_q, out_cnt_d;
  logic [LEN_W-1:0]    in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0]    win_idx_q, win_idx_d;
  logic [PHASE_DW-1:0] w0_q, w0_d, w1_q, w1_d;
  logic                done_q, done_d;

  logic [LEN_W-1:0]    pos_int;
  logic [FBIT-1:0]     pos_frac;
  logic                need_shift, in_avail, src_hs;
  logic                src_rdy_c, ld_c, can_ld;
  logic [PHASE_DW-1:0] p1_c, p2_c;
  logic [FBIT-1:0]     frac_c;
  logic [LEN_W-1:0]    out_cnt_nx;

  assign pos_int    = pos_q[POS_W-1:FBIT];
  assign pos_frac   = pos_q[FBIT-1:0];
  assign need_shift = pos_int > win_idx_q;
  assign in_avail   = in_cnt_q < in_len_q;
  assign src_hs     = bus.src_valid && src_rdy_c;
  assign out_cnt_nx = out_cnt_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    in_len_d  = in_len_q;
    out_len_d = out_len_q;
    pos_d     = pos_q;
    out_cnt_d = out_cnt_q;
    in_cnt_d  = in_cnt_q;
    win_idx_d = win_idx_q;
    w0_d      = w0_q;
    w1_d      = w1_q;
    done_d    = 1'b0;
    src_rdy_c = 1'b0;
    ld_c      = 1'b0;
    p1_c      = w0_q;
    p2_c      = w1_q;
    frac_c    = pos_frac;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          step_d    = step;
          in_len_d  = in_len;
          out_len_d = out_len;
          pos_d     = '0;
          out_cnt_d = '0;
          in_cnt_d  = '0;
          win_idx_d = '0;
          state_d   = ST_FILL;
        end
      end

      ST_FILL: begin
        src_rdy_c = 1'b1;
        if (src_hs) begin
          in_cnt_d = in_cnt_q + LEN_W'(1);
          if (in_cnt_q == '0) begin
            w0_d = bus.src_phase;
          end else begin
            w1_d    = bus.src_phase;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (!need_shift) begin
          ld_c = 1'b1;
        end else if (in_avail) begin
          // window slides one sample; no pair this cycle
          src_rdy_c = 1'b1;
          if (src_hs) begin
            w0_d      = w1_q;
            w1_d      = bus.src_phase;
            win_idx_d = win_idx_q + LEN_W'(1);
            in_cnt_d  = in_cnt_q + LEN_W'(1);
          end
        end else begin
          // past the last sample: clamp to the right edge
          ld_c   = 1'b1;
          p1_c   = w1_q;
          frac_c = '0;
        end

        // position advances when the pair is committed to the output
        // register; the register then holds it until the handshake
        if (ld_c && can_ld) begin
          pos_d     = pos_q + step_q;
          out_cnt_d = out_cnt_nx;
          if (out_cnt_nx == out_len_q) state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (in_avail) begin
          src_rdy_c = 1'b1;
          if (src_hs) in_cnt_d = in_cnt_q + LEN_W'(1);
        end else if (!bus.phase_valid || bus.phase_ready) begin
          // last pair has left (or is leaving now)
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      in_len_q  <= '0;
      out_len_q <= '0;
      pos_q     <= '0;
      out_cnt_q <= '0;
      in_cnt_q  <= '0;
      win_idx_q <= '0;
      w0_q      <= '0;
      w1_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      in_len_q  <= in_len_d;
      out_len_q <= out_len_d;
      pos_q     <= pos_d;
      out_cnt_q <= out_cnt_d;
      in_cnt_q  <= in_cnt_d;
      win_idx_q <= win_idx_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      done_q    <= done_d;
    end
  end

  xyz_rectify_out_reg #(
    .PHASE_DW (PHASE_DW),
    .FBIT     (FBIT),
    .PASS_DW  (PASS_DW)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (ld_c),
    .p1_i     (p1_c),
    .p2_i     (p2_c),
    .frac_i   (frac_c),
    .pass_i   (PASS_DW'(out_cnt_q)),
    .rdy_i    (bus.phase_ready),
    .can_ld_o (can_ld),
    .vld_o    (bus.phase_valid),
    .p1_o     (bus.phase1),
    .p2_o     (bus.phase2),
    .frac_o   (bus.phase_frac),
    .pass_o   (bus.phase_pass_data)
  );

  assign bus.src_ready = src_rdy_c;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_xyz_rectify_phase_pair_gen.sv
module tb_xyz_rectify_phase_pair_gen;

  typedef struct packed {
    logic [14:0] p1;
    logic [14:0] p2;
    logic [7:0]  frac;
    logic [7:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [18:0] step = '0;
  logic [10:0] in_len = '0;
  logic [10:0] out_len = '0;
  logic        busy, done;

  xyz_rectify_phase_pair_gen_if bus ();

  xyz_rectify_phase_pair_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .step    (step),
    .in_len  (in_len),
    .out_len (out_len),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs_cyc = -1;
  int ready_pct = 100;
  exp_t        exp_q[$];
  logic [14:0] src_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // source driver: presents queue head, pops on handshake
  initial begin : src_drv
    bit fire;
    bus.src_valid = 1'b0;
    bus.src_phase = '0;
    forever begin
      @(negedge clk);
      fire = bus.src_valid && bus.src_ready && !rst;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        bus.src_valid = 1'b1;
        bus.src_phase = src_q[0];
      end else begin
        bus.src_valid = 1'b0;
      end
    end
  end

  initial begin : rdy_drv
    bus.phase_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.phase_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // monitor: pops scoreboard on each output handshake, checks hold on stalls
  initial begin : mon
    bit   stall;
    exp_t held, got, e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      got = {bus.phase1, bus.phase2, bus.phase_frac, bus.phase_pass_data};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!bus.phase_valid || got !== held) begin
            failures++;
            $display("FAIL hold: got v=%0b (%0d,%0d,%0d,#%0d) want v=1 (%0d,%0d,%0d,#%0d)",
                     bus.phase_valid, got.p1, got.p2, got.frac, got.idx,
                     held.p1, held.p2, held.frac, held.idx);
          end
        end
        if (bus.phase_valid && bus.phase_ready) begin
          checks++;
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pair: got (%0d,%0d,%0d,#%0d) want none",
                     got.p1, got.p2, got.frac, got.idx);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              failures++;
              $display("FAIL pair: got (%0d,%0d,%0d,#%0d) want (%0d,%0d,%0d,#%0d)",
                       got.p1, got.p2, got.frac, got.idx, e.p1, e.p2, e.frac, e.idx);
            end
          end
        end
        stall = bus.phase_valid && !bus.phase_ready;
        held  = got;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_pair(input int p1, input int p2, input int fr, input int idx);
    exp_t e;
    e.p1   = 15'(p1);
    e.p2   = 15'(p2);
    e.frac = 8'(fr);
    e.idx  = 8'(idx);
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    exp_q.delete();
    src_q.delete();
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic run_line(input int st, input int il, input int ol,
                          input bit chk_lat, input bit mid_start, input string nm);
    bit seen;
    step    = 19'(st);
    in_len  = 11'(il);
    out_len = 11'(ol);
    start   = 1'b1;
    tick;
    start   = 1'b0;
    @(negedge clk);
    chk({nm, "_busy"}, int'(busy), 1);
    if (mid_start) begin
      // must be ignored: would otherwise shorten the line to one pair
      tick;
      step    = 19'd1;
      in_len  = 11'd2;
      out_len = 11'd1;
      start   = 1'b1;
      tick;
      start   = 1'b0;
    end
    seen = 1'b0;
    for (int n = 0; n < 40000 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
    if (!seen) begin
      do_reset;
    end else begin
      if (chk_lat) chk({nm, "_done_latency"}, cyc - last_hs_cyc, 1);
      @(negedge clk);
      chk({nm, "_done_pulse_end"}, int'(done), 0);
      chk({nm, "_busy_end"}, int'(busy), 0);
      chk({nm, "_pairs_left"}, exp_q.size(), 0);
      chk({nm, "_samples_left"}, src_q.size(), 0);
    end
  endtask

  initial begin : main
    logic [14:0] s[1024];
    int pos, ii;

    rst = 1'b1;
    tick; tick; tick;
    @(negedge clk);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_done",   int'(done), 0);
    chk("rst_pvalid", int'(bus.phase_valid), 0);
    chk("rst_sready", int'(bus.src_ready), 0);
    chk("rst_phase1", int'(bus.phase1), 0);
    chk("rst_pass",   int'(bus.phase_pass_data), 0);
    tick;
    rst = 1'b0;
    tick;

    // unit step, edge clamp on last pair
    ready_pct = 100;
    src_q = '{15'd100, 15'd200, 15'd300, 15'd400};
    push_pair(100, 200, 0, 0); push_pair(200, 300, 0, 1);
    push_pair(300, 400, 0, 2); push_pair(400, 400, 0, 3);
    run_line(256, 4, 4, 1'b1, 1'b0, "l4");

    // half step on the minimum line
    src_q = '{15'd10, 15'd20};
    push_pair(10, 20, 0, 0); push_pair(10, 20, 128, 1); push_pair(20, 20, 0, 2);
    run_line(128, 2, 3, 1'b1, 1'b0, "l2");

    // double step, leftover sample drained; stray start ignored
    src_q = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd5};
    push_pair(1, 2, 0, 0); push_pair(3, 4, 0, 1);
    run_line(512, 5, 2, 1'b0, 1'b1, "drain");

    // values near the phase wrap pass untouched
    src_q = '{15'd32700, 15'd50};
    push_pair(32700, 50, 0, 0); push_pair(32700, 50, 100, 1);
    run_line(100, 2, 2, 1'b1, 1'b0, "wrap");

    // reset while a pair is stalled in RUN
    ready_pct = 0;
    src_q = '{15'd100, 15'd200, 15'd300, 15'd400};
    push_pair(100, 200, 0, 0);
    step = 19'd256; in_len = 11'd4; out_len = 11'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    @(negedge clk);
    chk("mid_pvalid_before", int'(bus.phase_valid), 1);
    chk("mid_busy_before", int'(busy), 1);
    tick;
    rst = 1'b1;
    exp_q.delete();
    src_q.delete();
    tick;
    @(negedge clk);
    chk("mid_rst_pvalid", int'(bus.phase_valid), 0);
    chk("mid_rst_sready", int'(bus.src_ready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    tick;
    rst = 1'b0;
    ready_pct = 100;
    tick;
    tick;
    src_q = '{15'd100, 15'd200, 15'd300, 15'd400};
    push_pair(100, 200, 0, 0); push_pair(200, 300, 0, 1);
    push_pair(300, 400, 0, 2); push_pair(400, 400, 0, 3);
    run_line(256, 4, 4, 1'b1, 1'b0, "post_rst");

    // long line under heavy backpressure against a reference walk
    ready_pct = 10;
    for (int i = 0; i < 1024; i++) begin
      s[i] = 15'($urandom);
      src_q.push_back(s[i]);
    end
    for (int k = 0; k < 800; k++) begin
      pos = k * 330;
      ii  = pos / 256;
      if (ii + 1 < 1024) push_pair(int'(s[ii]), int'(s[ii+1]), pos % 256, k % 256);
      else               push_pair(int'(s[1023]), int'(s[1023]), 0, k % 256);
    end
    run_line(330, 1024, 800, 1'b0, 1'b0, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
